// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MAR/MDR strobes and memory handshakes for one
// 18-bit memory access at a time, arbitrating fetch and data requesters.
`default_nettype none

module mem_access_ctrl #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic f_req,
    output logic f_ack,
    input  logic d_req,
    input  logic d_we,
    output logic d_ack,
    output logic err,
    output logic busy,
    output logic sel_MAR,
    output logic ld_MAR,
    output logic wr_MDR_Mem,
    output logic wr_MDR_Bus,
    output logic re_MDR,
    output logic mem_rd,
    output logic mem_wr,
    input  logic mem_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ADDR     = 4'd1,
        RD_WAIT  = 4'd2,
        RD_LATCH = 4'd3,
        RD_OUT   = 4'd4,
        WR_LOAD  = 4'd5,
        WR_MEM   = 4'd6,
        DONE     = 4'd7,
        ERR      = 4'd8
    } state_t;

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          wr_q, wr_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pick;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        wr_d    = wr_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        pick    = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie, serve the port that was not granted last.
                if (f_req && d_req) pick = ~last_q;
                else                pick = d_req;
                if (f_req || d_req) begin
                    gnt_d   = pick;
                    wr_d    = pick & d_we;
                    last_d  = pick;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                cnt_d   = '0;
                state_d = wr_q ? WR_LOAD : RD_WAIT;
            end
            RD_WAIT, WR_MEM: begin
                if (mem_ready) begin
                    state_d = (state_q == RD_WAIT) ? RD_LATCH : DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RD_LATCH: state_d = RD_OUT;
            RD_OUT:   state_d = DONE;
            WR_LOAD: begin
                cnt_d   = '0;
                state_d = WR_MEM;
            end
            DONE, ERR: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that they are registered
    // and valid for exactly the cycle spent in that state.
    logic f_ack_d, d_ack_d, err_d, busy_d, sel_d, ld_d;
    logic wmm_d, wmb_d, re_d, rd_d, wr_strb_d;

    always_comb begin
        busy_d    = (state_d != IDLE);
        sel_d     = busy_d & gnt_d;
        ld_d      = (state_d == ADDR);
        rd_d      = (state_d == RD_WAIT) || (state_d == RD_LATCH);
        wmm_d     = (state_d == RD_LATCH);
        re_d      = (state_d == RD_OUT);
        wmb_d     = (state_d == WR_LOAD);
        wr_strb_d = (state_d == WR_MEM);
        err_d     = (state_d == ERR);
        f_ack_d   = ((state_d == DONE) || (state_d == ERR)) && !gnt_d;
        d_ack_d   = ((state_d == DONE) || (state_d == ERR)) && gnt_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            wr_q       <= 1'b0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
            f_ack      <= 1'b0;
            d_ack      <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            sel_MAR    <= 1'b0;
            ld_MAR     <= 1'b0;
            wr_MDR_Mem <= 1'b0;
            wr_MDR_Bus <= 1'b0;
            re_MDR     <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            wr_q       <= wr_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            f_ack      <= f_ack_d;
            d_ack      <= d_ack_d;
            err        <= err_d;
            busy       <= busy_d;
            sel_MAR    <= sel_d;
            ld_MAR     <= ld_d;
            wr_MDR_Mem <= wmm_d;
            wr_MDR_Bus <= wmb_d;
            re_MDR     <= re_d;
            mem_rd     <= rd_d;
            mem_wr     <= wr_strb_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed scenario bench for mem_access_ctrl.
`default_nettype none

module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic f_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
    logic f_ack, d_ack, err, busy, sel_MAR, ld_MAR;
    logic wr_MDR_Mem, wr_MDR_Bus, re_MDR, mem_rd, mem_wr;
    logic [10:0] outs;

    int total = 0;
    int bad   = 0;

    mem_access_ctrl #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_ack(f_ack),
        .d_req(d_req), .d_we(d_we), .d_ack(d_ack),
        .err(err), .busy(busy),
        .sel_MAR(sel_MAR), .ld_MAR(ld_MAR),
        .wr_MDR_Mem(wr_MDR_Mem), .wr_MDR_Bus(wr_MDR_Bus), .re_MDR(re_MDR),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ready(mem_ready)
    );

    // {f_ack,d_ack,err,busy,sel_MAR,ld_MAR,wr_MDR_Mem,wr_MDR_Bus,re_MDR,mem_rd,mem_wr}
    assign outs = {f_ack, d_ack, err, busy, sel_MAR, ld_MAR,
                   wr_MDR_Mem, wr_MDR_Bus, re_MDR, mem_rd, mem_wr};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            total++;
            if ((32'(ld_MAR) + 32'(wr_MDR_Mem) + 32'(wr_MDR_Bus) + 32'(re_MDR)) > 1 ||
                (mem_rd && mem_wr) || (f_ack && d_ack)) begin
                bad++;
                $display("FAIL mutex t=%0t outs=%b required at most one MDR/MAR strobe, one mem strobe, one ack",
                         $time, outs);
            end
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1;
        total++;
        if (outs !== 11'b0) begin
            bad++;
            $display("FAIL reset_outs got=%b want=%b", outs, 11'b0);
        end
        cyc();
        rst = 1'b1;
        cyc();
        total++;
        if (outs !== 11'b0) begin
            bad++;
            $display("FAIL reset_idle got=%b want=%b", outs, 11'b0);
        end
    endtask

    task automatic test_fetch;
        logic [10:0] exp [1:6];
        exp[1] = 11'b00010100000;
        exp[2] = 11'b00010000010;
        exp[3] = 11'b00010010010;
        exp[4] = 11'b00010000100;
        exp[5] = 11'b10010000000;
        exp[6] = 11'b00000000000;
        mem_ready = 1'b1;
        f_req = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            cyc();
            total++;
            if (outs !== exp[c]) begin
                bad++;
                $display("FAIL fetch_cycle%0d got=%b want=%b", c, outs, exp[c]);
            end
            if (c == 5) f_req = 1'b0;
        end
    endtask

    task automatic test_write;
        logic [10:0] exp [1:8];
        exp[1] = 11'b00011100000;
        exp[2] = 11'b00011001000;
        exp[3] = 11'b00011000001;
        exp[4] = 11'b00011000001;
        exp[5] = 11'b00011000001;
        exp[6] = 11'b00011000001;
        exp[7] = 11'b01011000000;
        exp[8] = 11'b00000000000;
        mem_ready = 1'b0;
        d_we = 1'b1;
        d_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            total++;
            if (outs !== exp[c]) begin
                bad++;
                $display("FAIL write_cycle%0d got=%b want=%b", c, outs, exp[c]);
            end
            if (c == 2) d_we = 1'b0;
            if (c == 6) mem_ready = 1'b1;
            if (c == 7) d_req = 1'b0;
        end
    endtask

    task automatic test_arbitration;
        logic exp_g [0:3];
        int   n;
        exp_g[0] = 1'b1; exp_g[1] = 1'b0; exp_g[2] = 1'b1; exp_g[3] = 1'b0;
        test_reset();
        mem_ready = 1'b1;
        d_we = 1'b0;
        f_req = 1'b1;
        d_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            do begin cyc(); n++; end while (!ld_MAR && n < 12);
            total++;
            if (!ld_MAR || sel_MAR !== exp_g[g]) begin
                bad++;
                $display("FAIL arb_grant%0d ld=%b sel_MAR=%b want sel_MAR=%b", g, ld_MAR, sel_MAR, exp_g[g]);
            end
            n = 0;
            do begin cyc(); n++; end while (!(f_ack || d_ack) && n < 12);
            total++;
            if (d_ack !== exp_g[g] || f_ack !== !exp_g[g] || err !== 1'b0) begin
                bad++;
                $display("FAIL arb_ack%0d got f_ack=%b d_ack=%b err=%b want d_ack=%b", g, f_ack, d_ack, err, exp_g[g]);
            end
        end
        f_req = 1'b0;
        d_req = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_timeout;
        int nrd;
        int n;
        nrd = 0;
        n = 0;
        mem_ready = 1'b0;
        d_we = 1'b0;
        d_req = 1'b1;
        do begin
            cyc();
            n++;
            if (mem_rd) nrd++;
        end while (!(f_ack || d_ack) && n < 40);
        d_req = 1'b0;
        total++;
        if (nrd != 8) begin
            bad++;
            $display("FAIL timeout_rd_cycles got=%0d want=8", nrd);
        end
        total++;
        if ({f_ack, d_ack, err} !== 3'b011) begin
            bad++;
            $display("FAIL timeout_ack got f_ack,d_ack,err=%b want=011", {f_ack, d_ack, err});
        end
        cyc();
        total++;
        if (outs !== 11'b0) begin
            bad++;
            $display("FAIL timeout_idle got=%b want=%b", outs, 11'b0);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        mem_ready = 1'b0;
        d_we = 1'b1;
        d_req = 1'b1;
        cyc(); cyc(); cyc();
        total++;
        if (mem_wr !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_in_wrmem got mem_wr=%b want=1", mem_wr);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (outs !== 11'b0 || clk !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_async got=%b clk=%b want=%b clk=1", outs, clk, 11'b0);
        end
        d_req = 1'b0;
        d_we = 1'b0;
        cyc();
        rst = 1'b1;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (outs !== 11'b0) n++;
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL rstmid_no_ack got %0d active cycles want=0", n);
        end
        mem_ready = 1'b1;
        f_req = 1'b1;
        cyc();
        total++;
        if (outs !== 11'b00010100000) begin
            bad++;
            $display("FAIL rstmid_restart got=%b want=%b", outs, 11'b00010100000);
        end
        n = 0;
        do begin cyc(); n++; end while (!f_ack && n < 12);
        f_req = 1'b0;
        total++;
        if (f_ack !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_restart_ack got=%b want=1", f_ack);
        end
        cyc();
    endtask

    task automatic test_drop_req;
        int n;
        mem_ready = 1'b0;
        d_we = 1'b0;
        d_req = 1'b1;
        cyc(); cyc();
        total++;
        if (mem_rd !== 1'b1 || sel_MAR !== 1'b1) begin
            bad++;
            $display("FAIL drop_rdwait got mem_rd=%b sel=%b want 1 1", mem_rd, sel_MAR);
        end
        d_req = 1'b0;
        cyc(); cyc();
        mem_ready = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (!(f_ack || d_ack) && n < 12);
        total++;
        if ({f_ack, d_ack, err} !== 3'b010) begin
            bad++;
            $display("FAIL drop_ack got f_ack,d_ack,err=%b want=010", {f_ack, d_ack, err});
        end
        cyc();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL drop_idle got busy=%b want=0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write();
        test_arbitration();
        test_timeout();
        test_reset_mid();
        test_drop_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences the memory address register, the memory data register and the external memory strobes for one 18-bit memory access at a time.
- Arbitrates between two requesters: the instruction-fetch port (read only) and the data port (read or write).
- Drives the MDR control strobes (re_MDR, wr_MDR_Mem, wr_MDR_Bus) and the MAR load/select.
- Detects memory that never answers and flags the access as a timeout error.

Parameters:
TIMEOUT, 8, max consecutive cycles waiting for mem_ready in RD_WAIT/WR_MEM before abort; legal range 1..255.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-low
f_req  in  1  fetch read request; level, held until f_ack
f_ack  out  1  one-cycle pulse: fetch access finished
d_req  in  1  data access request; level, held until d_ack
d_we  in  1  data direction: 1 write, 0 read; sampled with d_req
d_ack  out  1  one-cycle pulse: data access finished
err  out  1  high together with f_ack/d_ack when the access timed out
busy  out  1  high in every state except IDLE
sel_MAR  out  1  MAR address source: 0 fetch PC, 1 data address; valid ADDR..DONE/ERR
ld_MAR  out  1  load MAR
wr_MDR_Mem  out  1  MDR captures memory read data
wr_MDR_Bus  out  1  MDR captures bus write data
re_MDR  out  1  MDR drives MDRout
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
mem_ready  in  1  memory completion, sampled at clk edge

Behaviour:
- Moore FSM. All outputs are decoded from registered state, gnt and the wait counter only; no input-to-output combinational path.
- States: IDLE, ADDR, RD_WAIT, RD_LATCH, RD_OUT, WR_LOAD, WR_MEM, DONE, ERR.
- Reset (rst=0, asynchronous):
  - state=IDLE, all outputs 0, counter 0, gnt=0.
  - last_gnt=0 (fetch), so the first tie goes to data.
  - Reset mid-access aborts immediately; there is no ack for the aborted access.
- IDLE:
  - Requests are sampled only here.
  - One request: grant it.
  - Both requests: grant the port not recorded in last_gnt (round robin).
  - On grant: latch gnt (0 fetch / 1 data), latch wr = gnt & d_we, update last_gnt, go to ADDR.
- ADDR: ld_MAR=1, sel_MAR=gnt for one cycle. Next state is WR_LOAD if wr, else RD_WAIT.
- RD_WAIT:
  - mem_rd=1; counter increments each cycle.
  - mem_ready=1 → RD_LATCH.
  - Else, when counter reaches TIMEOUT-1 → ERR.
- RD_LATCH: mem_rd=1, wr_MDR_Mem=1 for one cycle → RD_OUT.
- RD_OUT: re_MDR=1 for one cycle (MDRout valid from the following cycle) → DONE.
- WR_LOAD: wr_MDR_Bus=1 for one cycle → WR_MEM.
- WR_MEM: mem_wr=1; ready/timeout rules identical to RD_WAIT. mem_ready → DONE, timeout → ERR.
- DONE: ack of the granted port=1, err=0, one cycle → IDLE.
- ERR: all strobes 0, ack of the granted port=1, err=1, one cycle → IDLE.
- Counter clears on entry to RD_WAIT/WR_MEM. Width is ceil(log2(TIMEOUT+1)); it saturates and never wraps.
- Latency with mem_ready already high, counted from the req-sampling edge:
  - read: ack in cycle 5 (ADDR, RD_WAIT, RD_LATCH, RD_OUT, DONE).
  - write: ack in cycle 4 (ADDR, WR_LOAD, WR_MEM, DONE).
- Each extra low-ready cycle adds one cycle of latency.
- Requester rules:
  - Must drop req in the cycle after seeing ack; IDLE (one cycle minimum between accesses) samples again.
  - Dropping req mid-access does not cancel it; the ack is still issued.
  - A change of d_we after grant is ignored.
- Mutual exclusion: at most one of ld_MAR, wr_MDR_Mem, wr_MDR_Bus, re_MDR is high in any cycle. mem_rd and mem_wr are never both high. f_ack and d_ack are never both high.

Test Plan:
- Single fetch read, mem_ready tied 1: f_req at edge 0 → ld_MAR cycle 1 (sel_MAR=0), mem_rd cycles 2-3, wr_MDR_Mem cycle 3, re_MDR cycle 4, f_ack=1 err=0 cycle 5, busy low cycle 6.
- Data write, d_we=1, mem_ready low for 3 cycles then high → wr_MDR_Bus cycle 2, mem_wr cycles 3-6, d_ack cycle 7, mem_rd never high.
- f_req and d_req both high after reset → data granted first (sel_MAR=1). Fetch is granted at the next IDLE. Repeat with both held continuously: grants alternate D,F,D,F.
- Read with mem_ready stuck 0, TIMEOUT=8 → mem_rd high exactly 8 cycles, then ERR: d_ack=1 and err=1 for one cycle, then IDLE with busy=0 and no strobes.
- rst pulled low during WR_MEM → all outputs 0 immediately, without waiting for clk. After release, no ack is issued and a new request starts at ADDR normally.
- d_req dropped during RD_WAIT → access completes and d_ack is still pulsed. Mutual-exclusion assertions hold across all scenarios.
